// File: rtl/vector_reducer.sv
// rtl/vector_reducer.sv - streaming pipelined SUM/MIN/MAX tree reduction of a LENGTH-element vector
// Optional feature macro: VECTOR_REDUCER_MASK_EN (adds per-element elem_mask input).
module vector_reducer #(
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH     = 8,
    parameter int SIGNED     = 0,
    localparam int NO_OF_STAGE  = $clog2(LENGTH),
    localparam int RESULT_WIDTH = DATA_WIDTH + $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LENGTH*DATA_WIDTH-1:0] data_in,
    input  logic [1:0]                   op_sel,
`ifdef VECTOR_REDUCER_MASK_EN
    input  logic [LENGTH-1:0]            elem_mask,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RESULT_WIDTH-1:0]      out_data,
    output logic                         busy
);

    localparam int NS     = NO_OF_STAGE;
    localparam int RW     = RESULT_WIDTH;
    localparam int LEAVES = 1 << NS;
    localparam logic [1:0] OP_MIN = 2'b01;
    localparam logic [1:0] OP_MAX = 2'b10;

    function automatic logic [RW-1:0] f_ext(input logic [DATA_WIDTH-1:0] x);
        logic [RW-1:0] v;
        if (SIGNED != 0) v = {{NS{x[DATA_WIDTH-1]}}, x};
        else             v = {{NS{1'b0}}, x};
        return v;
    endfunction

    function automatic logic [RW-1:0] f_identity(input logic [1:0] op);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (op == OP_MIN)
            v = (SIGNED != 0) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : {DATA_WIDTH{1'b1}};
        else if (op == OP_MAX)
            v = (SIGNED != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};
        return f_ext(v);
    endfunction

    function automatic logic [RW-1:0] f_combine(input logic [1:0] op,
                                                input logic [RW-1:0] a,
                                                input logic [RW-1:0] b);
        logic          lt;
        logic [RW-1:0] r;
        lt = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            OP_MIN:  r = lt ? a : b;
            OP_MAX:  r = lt ? b : a;
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic [LENGTH-1:0] w_mask;
`ifdef VECTOR_REDUCER_MASK_EN
    assign w_mask = elem_mask;
`else
    assign w_mask = '1;
`endif

    // Heap layout: node i has children 2i and 2i+1; leaves occupy LEAVES..2*LEAVES-1.
    logic [RW-1:0] w_leaf [LEAVES];
    logic [RW-1:0] w_next [1:LEAVES-1];
    logic [RW-1:0] r_node [1:LEAVES-1];
    logic [1:0]    r_op   [1:NS];
    logic [NS:1]   r_vld;
    logic          w_advance;

    for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
        if (j < LENGTH) begin : g_elem
            assign w_leaf[j] = w_mask[j] ? f_ext(data_in[j*DATA_WIDTH +: DATA_WIDTH])
                                         : f_identity(op_sel);
        end else begin : g_pad
            assign w_leaf[j] = f_identity(op_sel);
        end
    end

    for (genvar i = 1; i < LEAVES; i++) begin : g_node
        localparam int LVL = NS + 1 - $clog2(i + 1);
        logic [1:0]    w_op;
        logic [RW-1:0] w_a;
        logic [RW-1:0] w_b;
        if (LVL == 1) begin : g_from_leaf
            assign w_op = op_sel;
            assign w_a  = w_leaf[2*i - LEAVES];
            assign w_b  = w_leaf[2*i + 1 - LEAVES];
        end else begin : g_from_node
            assign w_op = r_op[LVL-1];
            assign w_a  = r_node[2*i];
            assign w_b  = r_node[2*i + 1];
        end
        assign w_next[i] = f_combine(w_op, w_a, w_b);
    end

    assign w_advance = !r_vld[NS] || out_ready;
    assign in_ready  = w_advance && !flush;
    assign out_valid = r_vld[NS];
    assign out_data  = r_node[1];
    assign busy      = |r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 1; k <= NS; k++) r_op[k] <= '0;
            for (int i = 1; i < LEAVES; i++) r_node[i] <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else if (w_advance) begin
            r_vld[1] <= in_valid;
            r_op[1]  <= op_sel;
            for (int k = 2; k <= NS; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_op[k]  <= r_op[k-1];
            end
            for (int i = 1; i < LEAVES; i++) r_node[i] <= w_next[i];
        end
    end

endmodule

// File: tb/tb_vector_reducer.sv
// tb/tb_vector_reducer.sv - self-checking bench for vector_reducer (unsigned L=8 and signed L=5 instances)
module tb_vector_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [63:0] data_in;
    logic [1:0]  op_sel;
    logic        in_ready, out_valid, busy;
    logic [10:0] out_data;

    logic        s_in_valid, s_out_ready, s_flush;
    logic [39:0] s_data;
    logic [1:0]  s_op;
    logic        s_in_ready, s_out_valid, s_busy;
    logic [10:0] s_out_data;

`ifdef VECTOR_REDUCER_MASK_EN
    logic [7:0] elem_mask;
    logic [4:0] s_mask;
`endif

    vector_reducer #(.DATA_WIDTH(8), .LENGTH(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .op_sel(op_sel),
`ifdef VECTOR_REDUCER_MASK_EN
        .elem_mask(elem_mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    vector_reducer #(.DATA_WIDTH(8), .LENGTH(5), .SIGNED(1)) u_sdut (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .data_in(s_data), .op_sel(s_op),
`ifdef VECTOR_REDUCER_MASK_EN
        .elem_mask(s_mask),
`endif
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int stalls = 0;
    logic [10:0] q_u[$];
    logic [10:0] q_s[$];
    int          q_t[$];

    typedef struct {
        logic [63:0] data;
        logic [1:0]  op;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl[12];

    typedef struct {
        logic [39:0] data;
        logic [1:0]  op;
        logic [10:0] exp;
    } svec_t;
    svec_t stbl[7];

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q_u.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d with no result expected", out_data);
            end else begin
                chk("out_u", out_data, q_u.pop_front());
                q_t.push_back(cycle);
            end
        end
        if (!rst && s_out_valid && s_out_ready) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_s: got %0d with no result expected", s_out_data);
            end else begin
                chk("out_s", s_out_data, q_s.pop_front());
            end
        end
    end

    function automatic logic [10:0] model_u(input logic [63:0] d, input logic [1:0] op);
        logic [10:0] acc, e;
        acc = (op == 2'b01) ? 11'd255 : 11'd0;
        for (int j = 0; j < 8; j++) begin
            e = {3'b000, d[j*8 +: 8]};
            case (op)
                2'b01:   if (e < acc) acc = e;
                2'b10:   if (e > acc) acc = e;
                default: acc = acc + e;
            endcase
        end
        return acc;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that accepted the vector.
    task automatic send(input bit s, input logic [63:0] d, input logic [1:0] op, input logic [10:0] exp);
        if (s) begin s_in_valid = 1'b1; s_data = d[39:0]; s_op = op; end
        else   begin in_valid   = 1'b1; data_in = d;      op_sel = op; end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s ? s_in_ready : in_ready) begin
                if (s) q_s.push_back(exp);
                else   q_u.push_back(exp);
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready low for 50 cycles, expected acceptance");
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (q_u.size() == 0 && q_s.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (q_u.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q_u.size(), q_s.size());
            q_u.delete();
            q_s.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          s0;
        logic [63:0] d;
        logic [1:0]  op;

        tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 11'd2040};
        tbl[1]  = '{64'h0807_0605_0403_0201, 2'b00, 11'd36};
        tbl[2]  = '{64'h0807_0605_0403_0201, 2'b01, 11'd1};
        tbl[3]  = '{64'h0807_0605_0403_0201, 2'b10, 11'd8};
        tbl[4]  = '{64'h0807_0605_0403_0201, 2'b00, 11'd36};
        tbl[5]  = '{64'h0807_0605_0403_0201, 2'b11, 11'd36};
        tbl[6]  = '{64'h0000_0000_0000_0000, 2'b01, 11'd0};
        tbl[7]  = '{64'h7F40_2010_00FE_0180, 2'b00, 11'd622};
        tbl[8]  = '{64'h7F40_2010_00FE_0180, 2'b10, 11'd254};
        tbl[9]  = '{64'h7F40_2010_00FE_0180, 2'b01, 11'd0};
        tbl[10] = '{64'h03FF_FFFF_FFFF_FFFF, 2'b01, 11'd3};
        tbl[11] = '{64'h0000_0000_0000_00C8, 2'b10, 11'd200};

        stbl[0] = '{40'h05_00_80_07_FD, 2'b01, 11'h780};
        stbl[1] = '{40'h05_00_80_07_FD, 2'b10, 11'd7};
        stbl[2] = '{40'h05_00_80_07_FD, 2'b00, 11'h789};
        stbl[3] = '{40'hFB_FC_FD_FE_FF, 2'b01, 11'h7FB};
        stbl[4] = '{40'hFB_FC_FD_FE_FF, 2'b10, 11'h7FF};
        stbl[5] = '{40'h05_04_03_02_01, 2'b01, 11'd1};
        stbl[6] = '{40'h05_04_03_02_01, 2'b00, 11'd15};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; data_in = '0; op_sel = '0; out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_data = '0; s_op = '0; s_out_ready = 1'b1;
`ifdef VECTOR_REDUCER_MASK_EN
        elem_mask = 8'hFF;
        s_mask    = 5'h1F;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {10'b0, out_valid}, 11'd0);
        chk("rst_out_data", out_data, 11'd0);
        chk("rst_busy", {10'b0, busy}, 11'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {10'b0, in_ready}, 11'd1);
        @(posedge clk); #1;

        // Latency: all-0xFF SUM
        send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 11'd2040);
        idle();
        @(negedge clk);
        chk("lat_edge1", {10'b0, out_valid}, 11'd0);
        @(negedge clk);
        chk("lat_edge2", {10'b0, out_valid}, 11'd0);
        @(negedge clk);
        chk("lat_edge3", {10'b0, out_valid}, 11'd1);
        @(posedge clk); #1;
        drain();

        // Table, back-to-back with mixed ops
        s0 = stalls;
        q_t.delete();
        foreach (tbl[i]) send(1'b0, tbl[i].data, tbl[i].op, tbl[i].exp);
        idle();
        drain();
        chk("b2b_in_ready_stalls", 11'(stalls - s0), 11'd0);
        chk("b2b_count", 11'(q_t.size()), 11'd12);
        if (q_t.size() == 12) chk("b2b_consecutive", 11'(q_t[11] - q_t[0]), 11'd11);

        for (int i = 0; i < 8; i++) begin
            d  = {$urandom, $urandom};
            op = 2'($urandom_range(0, 3));
            send(1'b0, d, op, model_u(d, op));
        end
        idle();
        drain();

        // Signed, LENGTH=5: padding must not leak into MIN/MAX
        foreach (stbl[i]) send(1'b1, {24'b0, stbl[i].data}, stbl[i].op, stbl[i].exp);
        idle();
        drain();

        // Backpressure with three vectors in flight
        out_ready = 1'b0;
        send(1'b0, tbl[1].data, 2'b00, 11'd36);
        send(1'b0, tbl[8].data, 2'b10, 11'd254);
        send(1'b0, tbl[2].data, 2'b01, 11'd1);
        idle();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_in_ready", {10'b0, in_ready}, 11'd0);
            chk("stall_out_valid", {10'b0, out_valid}, 11'd1);
            chk("stall_out_data", out_data, 11'd36);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Flush with two vectors in flight
        send(1'b0, tbl[1].data, 2'b00, 11'd36);
        send(1'b0, tbl[0].data, 2'b00, 11'd2040);
        idle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {10'b0, in_ready}, 11'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        q_u.delete();
        @(negedge clk);
        chk("flush_busy", {10'b0, busy}, 11'd0);
        chk("flush_out_valid", {10'b0, out_valid}, 11'd0);
        repeat (5) @(posedge clk);
        #1;
        send(1'b0, tbl[7].data, 2'b00, 11'd622);
        idle();
        drain();

        // Reset mid-operation
        send(1'b0, tbl[1].data, 2'b00, 11'd36);
        send(1'b0, tbl[3].data, 2'b10, 11'd8);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {10'b0, busy}, 11'd0);
        chk("midrst_out_valid", {10'b0, out_valid}, 11'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        q_u.delete();
        repeat (5) @(posedge clk);
        #1;
        send(1'b0, tbl[10].data, 2'b01, 11'd3);
        idle();
        drain();

`ifdef VECTOR_REDUCER_MASK_EN
        elem_mask = 8'b0000_1111;
        send(1'b0, 64'h5046_3C32_281E_140A, 2'b00, 11'd100);
        elem_mask = 8'h00;
        send(1'b0, 64'h0102_0304_0506_0708, 2'b01, 11'd255);
        send(1'b0, 64'h0102_0304_0506_0708, 2'b00, 11'd0);
        idle();
        elem_mask = 8'hFF;
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
